// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Sequencing controller for the multicycle MIPS datapath. A ten-state
//   instruction-phase FSM (fetch, decode, execute, memory, write-back) drives
//   the datapath mux selects, write enables and ALU operation class.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   Opcode      instruction[31:26] from the instruction register
//   Zero        ALU zero flag (used only for the branch PC enable)
//   MemReady    memory finishes the current access this cycle
//   PCWrite, PCWriteCond, PCEn       PC enables, PCEn = PCWrite | (PCWriteCond & Zero)
//   IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA
//                                    datapath controls
//   ALUSrcB     00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   ALUOp       00 add, 01 subtract, 10 use funct
//   PCSource    00 ALU result, 01 ALUOut, 10 jump target
//   IllegalOp   one-cycle pulse in DECODE on an unsupported opcode
//   State       current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t state_r;

    // Raw per-state decode, before the reset override of the enables.
    logic       pc_write_s, pc_write_cond_s, ior_d_s, mem_read_s, mem_write_s;
    logic       ir_write_s, memto_reg_s, reg_write_s, reg_dst_s, alu_src_a_s;
    logic       illegal_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

    // Instruction-phase FSM; Opcode is only looked at in DECODE and MEMADR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= MemReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_R:         state_r <= S_EXEC;
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_J:         state_r <= S_JUMP;
                        default:      state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    // An opcode that stopped being lw/sw here abandons the instruction.
                    case (Opcode)
                        OP_LW:   state_r <= S_MEMRD;
                        OP_SW:   state_r <= S_MEMWR;
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMRD:  state_r <= MemReady ? S_MEMWB : S_MEMRD;
                S_MEMWR:  state_r <= MemReady ? S_FETCH : S_MEMWR;
                S_EXEC:   state_r <= S_RWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_r <= S_FETCH;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; anything not named for a state stays 0.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        ior_d_s         = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        memto_reg_s     = 1'b0;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        alu_src_a_s     = 1'b0;
        illegal_s       = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                // IR load and PC+4 commit only on the cycle memory delivers.
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = MemReady;
                pc_write_s  = MemReady;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (Opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: illegal_s = 1'b0;
                    default:                          illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                ior_d_s    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                memto_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                ior_d_s     = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_source_s     = 2'b01;
                pc_write_cond_s = 1'b1;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Output stage: reset masks every enable so an aborted access writes nothing.
    always_comb begin
        IorD     = ior_d_s;
        MemtoReg = memto_reg_s;
        RegDst   = reg_dst_s;
        ALUSrcA  = alu_src_a_s;
        ALUSrcB  = alu_src_b_s;
        ALUOp    = alu_op_s;
        PCSource = pc_source_s;
        State    = state_r;
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCEn        = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            IllegalOp   = 1'b0;
        end else begin
            PCWrite     = pc_write_s;
            PCWriteCond = pc_write_cond_s;
            PCEn        = pc_write_s | (pc_write_cond_s & Zero);
            IRWrite     = ir_write_s;
            MemRead     = mem_read_s;
            MemWrite    = mem_write_s;
            RegWrite    = reg_write_s;
            IllegalOp   = illegal_s;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath. It holds the instruction-phase state machine (fetch, decode, execute, memory, write-back). Each cycle it drives the datapath mux selects, register/memory write enables and ALU operation class. It also forms the PC write enable, i.e. the branch AND of PCWriteCond and ALU Zero, ORed with PCWrite. A MemReady handshake stretches memory phases for slow memory.

## Interface
- No parameters; opcodes fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, j 6'b000010.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Opcode  input  6  instruction[31:26] from the instruction register
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, PCEn  output  1 each  PC enables; PCEn = PCWrite | (PCWriteCond & Zero)
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls
- ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  output  2  00 add, 01 subtract, 10 use funct
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- IllegalOp  output  1  one-cycle pulse on unsupported opcode
- State  output  4  current state encoding, for debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9. Codes 10-15 are unreachable and go to FETCH.
- Transitions:
  - FETCH -> DECODE if MemReady, else hold.
  - DECODE: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; any other opcode -> FETCH with IllegalOp=1 that cycle.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB if MemReady, else hold.
  - MEMWR -> FETCH if MemReady, else hold.
  - MEMWB, RWB, BRANCH and JUMP each -> FETCH.
  - EXEC -> RWB.
- Outputs are decoded from the state register. Any signal not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1. Held every wait cycle until MemReady.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, MemtoReg=0, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1.
  - JUMP: PCWrite=1, PCSource=10.
- PCEn is combinational from PCWrite, PCWriteCond and Zero in the same cycle.
- Opcode is sampled only in DECODE and MEMADR. It must be stable from the IR at those points; Opcode changes elsewhere are ignored.

## Timing
- Reset: while reset=1, these outputs are forced to 0 regardless of state: PCWrite, PCWriteCond, PCEn, IRWrite, MemRead, MemWrite, RegWrite, IllegalOp. On the edge where reset=1, State becomes 0. The first cycle after reset deasserts is FETCH.
- Reset mid-instruction (any state, including a MemReady wait) aborts the instruction. No partial write completes after the reset edge.
- Zero-wait cycle counts (FETCH through last state):
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady sampled outside FETCH, MEMRD or MEMWR has no effect.
- beq taken: PCEn=1 for exactly the one BRANCH cycle, when Zero=1. Not taken: PCEn=0.
- IllegalOp is high exactly one cycle, in DECODE. It is not registered.

## Test plan
- Reset: assert reset 2 cycles while in MEMWR with MemReady=0 -> MemWrite=0 during reset; State=0 on the cycle after release; FETCH outputs show MemRead=1, ALUSrcB=01.
- R-type (Opcode=0, MemReady=1): State sequence 0,1,6,7,0 -> ALUOp=10 in state 6; RegWrite=1 and RegDst=1 only in state 7; PCEn=1 only in state 0.
- lw with 2 wait cycles in MEMRD: sequence 0,1,2,3,3,3,4,0 -> MemRead=1 and IorD=1 for all three state-3 cycles; RegWrite=1 and MemtoReg=1 in state 4 only.
- sw (Opcode=101011), MemReady=0 for 1 cycle in FETCH: sequence 0,0,1,2,5,0 -> IRWrite=0 then 1 in FETCH; MemWrite=1 only in state 5.
- beq with Zero=1 and again with Zero=0: sequence 0,1,8,0 -> PCEn=1 in state 8 when Zero=1, 0 when Zero=0; PCSource=01 and ALUOp=01 in both runs.
- j, then illegal Opcode=6'b111111: j gives sequence 0,1,9,0 with PCEn=1 and PCSource=10 in state 9. The illegal opcode gives 0,1,0 with IllegalOp=1 only in state 1 and no write enable asserted.
